// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : ID/EX pipeline register feeding the ALU. Latches one decoded
//               instruction, resolves its A/B operands (register read with
//               EX/WB forwarding, immediate / shift-amount extension, LUI
//               form) and presents them registered to the ALU. Detects
//               load-use hazards and inserts bubbles, counting stall cycles.
//
// Ports       :
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        decode-side handshake
//   in_opcode, in_carry        passed through to the ALU
//   in_rs/rt/rd_addr           register numbers
//   in_rs_data, in_rt_data     register file read data
//   in_imm16, in_shamt         immediate and shift-amount fields
//   in_a_sel, in_b_sel         operand source selects
//   ex_*, wb_*                 forwarding sources (EX result, writeback)
//   flush                      drop held and offered instruction
//   out_valid / out_ready      ALU-side handshake
//   alu_a, alu_b, alu_opcode,
//   alu_carry_in, out_rd_addr  registered ALU inputs
//   stall_count                saturating count of load-use bubble cycles
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [4:0]        in_rs_addr,
  input  logic [4:0]        in_rt_addr,
  input  logic [4:0]        in_rd_addr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [15:0]       in_imm16,
  input  logic [4:0]        in_shamt,
  input  logic [1:0]        in_a_sel,
  input  logic [2:0]        in_b_sel,
  input  logic              in_carry,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_wr_addr,
  input  logic [DATA_W-1:0] ex_wr_data,
  input  logic              wb_wr_en,
  input  logic [4:0]        wb_wr_addr,
  input  logic [DATA_W-1:0] wb_wr_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic              alu_carry_in,
  output logic [4:0]        out_rd_addr,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [DATA_W-1:0] c_zero    = '0;
  localparam logic [CNT_W-1:0]  c_cnt_max = '1;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [OP_W-1:0]   r_alu_opcode;
  logic              r_alu_carry_in;
  logic [4:0]        r_out_rd_addr;
  logic [CNT_W-1:0]  r_stall_count;

  logic              w_adv;
  logic              w_hazard;
  logic              w_rs_used;
  logic              w_rt_used;
  logic              w_accept;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;

  // Forwarding: r0 is hard zero, the younger EX result beats WB.
  always_comb begin
    w_rs_val = in_rs_data;
    if (in_rs_addr == 5'd0)
      w_rs_val = c_zero;
    else if (ex_wr_en && (ex_wr_addr == in_rs_addr))
      w_rs_val = ex_wr_data;
    else if (wb_wr_en && (wb_wr_addr == in_rs_addr))
      w_rs_val = wb_wr_data;
  end

  always_comb begin
    w_rt_val = in_rt_data;
    if (in_rt_addr == 5'd0)
      w_rt_val = c_zero;
    else if (ex_wr_en && (ex_wr_addr == in_rt_addr))
      w_rt_val = ex_wr_data;
    else if (wb_wr_en && (wb_wr_addr == in_rt_addr))
      w_rt_val = wb_wr_data;
  end

  always_comb begin
    w_a = c_zero;
    case (in_a_sel)
      2'd0:    w_a = w_rs_val;
      2'd1:    w_a = w_rt_val;
      default: w_a = c_zero;
    endcase
  end

  always_comb begin
    w_b = c_zero;
    case (in_b_sel)
      3'd0:    w_b = w_rt_val;
      3'd1:    w_b = {{(DATA_W-16){in_imm16[15]}}, in_imm16};
      3'd2:    w_b = {{(DATA_W-16){1'b0}}, in_imm16};
      3'd3:    w_b = {{(DATA_W-5){1'b0}}, in_shamt};
      3'd4:    w_b = {{(DATA_W-5){1'b0}}, w_rs_val[4:0]};
      3'd5:    w_b = {in_imm16, {(DATA_W-16){1'b0}}};
      default: w_b = c_zero;
    endcase
  end

  // Only sources the instruction actually reads can cause a load-use stall,
  // so immediate forms behind a load proceed without a bubble.
  assign w_rs_used = (in_a_sel == 2'd0) || (in_b_sel == 3'd4);
  assign w_rt_used = (in_a_sel == 2'd1) || (in_b_sel == 3'd0);

  assign w_hazard = in_valid && ex_is_load && ex_wr_en && (ex_wr_addr != 5'd0) &&
                    ((w_rs_used && (ex_wr_addr == in_rs_addr)) ||
                     (w_rt_used && (ex_wr_addr == in_rt_addr)));

  assign w_adv    = !r_out_valid || out_ready;
  // During flush the offered instruction is consumed (and discarded).
  assign in_ready = (w_adv && !w_hazard) || flush;
  assign w_accept = in_valid && w_adv && !w_hazard && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_alu_a        <= c_zero;
      r_alu_b        <= c_zero;
      r_alu_opcode   <= '0;
      r_alu_carry_in <= 1'b0;
      r_out_rd_addr  <= 5'd0;
      r_stall_count  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      if (w_accept) begin
        r_out_valid    <= 1'b1;
        r_alu_a        <= w_a;
        r_alu_b        <= w_b;
        r_alu_opcode   <= in_opcode;
        r_alu_carry_in <= in_carry;
        r_out_rd_addr  <= in_rd_addr;
      end else begin
        // Bubble (hazard) or nothing offered: data outputs hold.
        r_out_valid <= 1'b0;
        if (w_hazard && (r_stall_count != c_cnt_max))
          r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_opcode   = r_alu_opcode;
  assign alu_carry_in = r_alu_carry_in;
  assign out_rd_addr  = r_out_rd_addr;
  assign stall_count  = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Directed self-checking bench for alu_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr;
  logic [31:0] in_rs_data, in_rt_data;
  logic [15:0] in_imm16;
  logic [4:0]  in_shamt;
  logic [1:0]  in_a_sel;
  logic [2:0]  in_b_sel;
  logic        in_carry;
  logic        ex_wr_en, ex_is_load;
  logic [4:0]  ex_wr_addr;
  logic [31:0] ex_wr_data;
  logic        wb_wr_en;
  logic [4:0]  wb_wr_addr;
  logic [31:0] wb_wr_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  alu_opcode;
  logic        alu_carry_in;
  logic [4:0]  out_rd_addr;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.DATA_W(32), .OP_W(6), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm16(in_imm16), .in_shamt(in_shamt),
    .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_carry(in_carry),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_carry_in(alu_carry_in), .out_rd_addr(out_rd_addr),
    .stall_count(stall_count)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_opcode = 0; in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0;
    in_rs_data = 0; in_rt_data = 0; in_imm16 = 0; in_shamt = 0;
    in_a_sel = 0; in_b_sel = 0; in_carry = 0;
    ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = 0; ex_wr_data = 0;
    wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic offer(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [15:0] imm, input logic [4:0] sh,
                       input logic [1:0] asel, input logic [2:0] bsel, input logic cin);
    in_valid = 1; in_opcode = op; in_rs_addr = rs; in_rt_addr = rt; in_rd_addr = rd;
    in_rs_data = rsd; in_rt_data = rtd; in_imm16 = imm; in_shamt = sh;
    in_a_sel = asel; in_b_sel = bsel; in_carry = cin;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin n_fail++; $display("FAIL reset_ab: got a=%h b=%h want 0", alu_a, alu_b); end
    n_checks++; if (alu_opcode !== 6'h0 || alu_carry_in !== 1'b0 || out_rd_addr !== 5'h0) begin n_fail++; $display("FAIL reset_ctl: got op=%h c=%b rd=%h want 0", alu_opcode, alu_carry_in, out_rd_addr); end
    n_checks++; if (stall_count !== 16'h0) begin n_fail++; $display("FAIL reset_stall: got %h want 0", stall_count); end
    reset = 0;
  endtask

  task automatic test_basic();
    idle();
    offer(6'h00, 5'd3, 5'd4, 5'd7, 32'd6, 32'h0A, 16'h0, 5'd0, 2'd0, 3'd0, 1'b1);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", in_ready); end
    step();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_checks++; if (alu_a !== 32'd6 || alu_b !== 32'h0A) begin n_fail++; $display("FAIL basic_ab: got a=%h b=%h want 6/0a", alu_a, alu_b); end
    n_checks++; if (alu_opcode !== 6'h00 || alu_carry_in !== 1'b1 || out_rd_addr !== 5'd7) begin n_fail++; $display("FAIL basic_ctl: got op=%h c=%b rd=%0d want 00/1/7", alu_opcode, alu_carry_in, out_rd_addr); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_forward();
    idle();
    ex_wr_en = 1; ex_wr_addr = 5; ex_wr_data = 32'h22;
    wb_wr_en = 1; wb_wr_addr = 5; wb_wr_data = 32'h33;
    offer(6'h01, 5'd5, 5'd0, 5'd1, 32'h1, 32'h0, 16'h0, 5'd0, 2'd0, 3'd2, 1'b0);
    step();
    n_checks++; if (alu_a !== 32'h22) begin n_fail++; $display("FAIL fwd_ex_prio: got %h want 22", alu_a); end
    ex_wr_en = 0;
    step();
    n_checks++; if (alu_a !== 32'h33) begin n_fail++; $display("FAIL fwd_wb: got %h want 33", alu_a); end
    ex_wr_en = 1; ex_wr_addr = 0; wb_wr_addr = 0;
    offer(6'h01, 5'd0, 5'd0, 5'd1, 32'h55, 32'h0, 16'h0, 5'd0, 2'd0, 3'd2, 1'b0);
    step();
    n_checks++; if (alu_a !== 32'h0) begin n_fail++; $display("FAIL fwd_r0: got %h want 0", alu_a); end
    ex_wr_en = 0; wb_wr_addr = 9; wb_wr_data = 32'h44;
    offer(6'h01, 5'd0, 5'd9, 5'd1, 32'h0, 32'h99, 16'h0, 5'd0, 2'd1, 3'd6, 1'b0);
    step();
    n_checks++; if (alu_a !== 32'h44 || alu_b !== 32'h0) begin n_fail++; $display("FAIL fwd_rt_wb: got a=%h b=%h want 44/0", alu_a, alu_b); end
    wb_wr_en = 0;
    offer(6'h01, 5'd0, 5'd9, 5'd1, 32'h0, 32'h99, 16'h0, 5'd0, 2'd1, 3'd0, 1'b0);
    step();
    n_checks++; if (alu_a !== 32'h99 || alu_b !== 32'h99) begin n_fail++; $display("FAIL fwd_rf: got a=%h b=%h want 99/99", alu_a, alu_b); end
    in_valid = 0;
    step();
  endtask

  task automatic test_imm();
    idle();
    offer(6'h02, 5'd2, 5'd0, 5'd1, 32'h25, 32'h0, 16'hFFF0, 5'd7, 2'd2, 3'd1, 1'b0);
    step();
    n_checks++; if (alu_b !== 32'hFFFFFFF0 || alu_a !== 32'h0) begin n_fail++; $display("FAIL imm_sext: got a=%h b=%h want 0/fffffff0", alu_a, alu_b); end
    in_b_sel = 3'd2; in_a_sel = 2'd3;
    step();
    n_checks++; if (alu_b !== 32'h0000FFF0 || alu_a !== 32'h0) begin n_fail++; $display("FAIL imm_zext: got a=%h b=%h want 0/0000fff0", alu_a, alu_b); end
    in_b_sel = 3'd5;
    step();
    n_checks++; if (alu_b !== 32'hFFF00000) begin n_fail++; $display("FAIL imm_lui: got %h want fff00000", alu_b); end
    in_b_sel = 3'd3;
    step();
    n_checks++; if (alu_b !== 32'h7) begin n_fail++; $display("FAIL imm_shamt: got %h want 7", alu_b); end
    in_b_sel = 3'd4; in_a_sel = 2'd0;
    step();
    n_checks++; if (alu_b !== 32'h5 || alu_a !== 32'h25) begin n_fail++; $display("FAIL imm_rs5: got a=%h b=%h want 25/5", alu_a, alu_b); end
    in_b_sel = 3'd7;
    step();
    n_checks++; if (alu_b !== 32'h0) begin n_fail++; $display("FAIL imm_bsel7: got %h want 0", alu_b); end
    in_valid = 0;
    step();
  endtask

  task automatic test_load_use();
    idle();
    ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 4; ex_wr_data = 32'h77;
    offer(6'h03, 5'd0, 5'd4, 5'd2, 32'h0, 32'h11, 16'h0, 5'd0, 2'd2, 3'd0, 1'b0);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_ready: got %b want 0", in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b0 || stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_bubble: got v=%b cnt=%0d want 0/1", out_valid, stall_count); end
    ex_is_load = 0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_release: got %b want 1", in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b1 || alu_b !== 32'h77 || stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_accept: got v=%b b=%h cnt=%0d want 1/77/1", out_valid, alu_b, stall_count); end
    ex_is_load = 1;
    offer(6'h03, 5'd0, 5'd4, 5'd2, 32'h0, 32'h11, 16'h0005, 5'd0, 2'd2, 3'd1, 1'b0);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_imm_ready: got %b want 1", in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b1 || alu_b !== 32'h5 || stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_imm: got v=%b b=%h cnt=%0d want 1/5/1", out_valid, alu_b, stall_count); end
    in_valid = 0; ex_is_load = 0; ex_wr_en = 0;
    step();
  endtask

  task automatic test_backpressure();
    idle();
    out_ready = 0;
    offer(6'h15, 5'd1, 5'd0, 5'd3, 32'h100, 32'h0, 16'h1234, 5'd0, 2'd0, 3'd2, 1'b1);
    step();
    // Next instruction is also load-use dependent: stalled by backpressure only.
    ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 6;
    offer(6'h2A, 5'd6, 5'd0, 5'd4, 32'h200, 32'h0, 16'h5678, 5'd0, 2'd0, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 0", i, in_ready); end
      step();
      n_checks++; if (out_valid !== 1'b1 || alu_a !== 32'h100 || alu_b !== 32'h1234 || alu_opcode !== 6'h15 || out_rd_addr !== 5'd3 || alu_carry_in !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b a=%h b=%h op=%h rd=%0d want 1/100/1234/15/3", i, out_valid, alu_a, alu_b, alu_opcode, out_rd_addr);
      end
    end
    flush = 1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b0 || stall_count !== 16'd1) begin n_fail++; $display("FAIL flush: got v=%b cnt=%0d want 0/1", out_valid, stall_count); end
    flush = 0; in_valid = 0; ex_wr_en = 0; ex_is_load = 0;
    step();
    n_checks++; if (out_valid !== 1'b0 || alu_opcode !== 6'h15) begin n_fail++; $display("FAIL flush_drop: got v=%b op=%h want 0/15", out_valid, alu_opcode); end
  endtask

  task automatic test_back_to_back();
    idle();
    offer(6'h01, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 16'h0, 5'd0, 2'd0, 3'd0, 1'b0);
    step();
    n_checks++; if (out_valid !== 1'b1 || alu_a !== 32'h11 || alu_b !== 32'h22) begin n_fail++; $display("FAIL b2b_first: got v=%b a=%h b=%h want 1/11/22", out_valid, alu_a, alu_b); end
    offer(6'h02, 5'd1, 5'd2, 5'd6, 32'h33, 32'h44, 16'h0, 5'd0, 2'd0, 3'd0, 1'b1);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b1 || alu_a !== 32'h33 || alu_b !== 32'h44 || alu_opcode !== 6'h02 || out_rd_addr !== 5'd6) begin
      n_fail++; $display("FAIL b2b_second: got v=%b a=%h b=%h op=%h rd=%0d want 1/33/44/02/6", out_valid, alu_a, alu_b, alu_opcode, out_rd_addr);
    end
    in_valid = 0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_saturate();
    idle();
    ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 8;
    offer(6'h04, 5'd8, 5'd0, 5'd1, 32'h0, 32'h0, 16'h0, 5'd0, 2'd0, 3'd2, 1'b0);
    repeat (65540) step();
    n_checks++; if (stall_count !== 16'hFFFF || out_valid !== 1'b0) begin n_fail++; $display("FAIL saturate: got cnt=%h v=%b want ffff/0", stall_count, out_valid); end
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    idle();
    out_ready = 0;
    offer(6'h3F, 5'd1, 5'd2, 5'd31, 32'hDEAD, 32'hBEEF, 16'h0, 5'd0, 2'd0, 3'd0, 1'b1);
    step();
    n_checks++; if (out_valid !== 1'b1 || alu_a !== 32'hDEAD) begin n_fail++; $display("FAIL rmid_load: got v=%b a=%h want 1/dead", out_valid, alu_a); end
    reset = 1; flush = 1;
    step();
    n_checks++; if (out_valid !== 1'b0 || alu_a !== 32'h0 || alu_b !== 32'h0 || alu_opcode !== 6'h0 || alu_carry_in !== 1'b0 || out_rd_addr !== 5'd0 || stall_count !== 16'h0) begin
      n_fail++; $display("FAIL rmid_clear: got v=%b a=%h b=%h op=%h c=%b rd=%0d cnt=%h want all 0", out_valid, alu_a, alu_b, alu_opcode, alu_carry_in, out_rd_addr, stall_count);
    end
    reset = 0;
    idle();
    step();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_basic();
    test_forward();
    test_imm();
    test_load_use();
    test_backpressure();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
